// File: rtl/tft_frame_sequencer_pkg.sv
// tft_frame_sequencer_pkg: shared states, TFT command codes, ROM entry layout and window word table
package tft_frame_sequencer_pkg;
  typedef enum logic [2:0] {
    S_RST_LO, S_RST_WAIT, S_INIT, S_IDLE, S_WIN, S_RAMWR, S_PIX
  } state_t;
  localparam logic [15:0] TFT_CMD_CASET = 16'h002A;
  localparam logic [15:0] TFT_CMD_PASET = 16'h002B;
  localparam logic [15:0] TFT_CMD_RAMWR = 16'h002C;
  localparam int ROM_RS  = 17;
  localparam int ROM_DLY = 16;
  // {rs, data} for the i-th of the ten CASET/PASET window writes
  function automatic logic [16:0] win_word(input logic [3:0] i, input logic [15:0] w1, input logic [15:0] h1);
    case (i)
      4'd0:    win_word = {1'b0, TFT_CMD_CASET};
      4'd3:    win_word = {1'b1, 8'h00, w1[15:8]};
      4'd4:    win_word = {1'b1, 8'h00, w1[7:0]};
      4'd5:    win_word = {1'b0, TFT_CMD_PASET};
      4'd8:    win_word = {1'b1, 8'h00, h1[15:8]};
      4'd9:    win_word = {1'b1, 8'h00, h1[7:0]};
      default: win_word = 17'h1_0000;
    endcase
  endfunction
endpackage

// File: rtl/tft_init_rom.sv
// tft_init_rom: panel init command list, addr -> {rs, delay flag, data}
//  addr   in  5   entry index
//  entry  out 18  bit17 rs, bit16 delay-after flag, [15:0] bus word
module tft_init_rom
  import tft_frame_sequencer_pkg::*;
(
  input  logic [4:0]  addr,
  output logic [17:0] entry
);
  always_comb begin
    case (addr)
      5'd0:    entry = {1'b0, 1'b1, 16'h0001};
      5'd1:    entry = {1'b0, 1'b0, 16'h0011};
      5'd2:    entry = {1'b1, 1'b0, 16'h0055};
      5'd3:    entry = {1'b0, 1'b0, 16'h0029};
      5'd4:    entry = {1'b0, 1'b0, 16'h003A};
      5'd5:    entry = {1'b1, 1'b0, 16'h0055};
      5'd6:    entry = {1'b0, 1'b0, 16'h0036};
      5'd7:    entry = {1'b1, 1'b0, 16'h0028};
      default: entry = {1'b0, 1'b0, 16'h0000};
    endcase
  end
endmodule

// File: rtl/tft_frame_sequencer.sv
// tft_frame_sequencer: 8080-style TFT reset/init/window/pixel-stream sequencer
//  clk28 in clock; rst in sync active-high reset
//  start_frame in frame request pulse; pix_data/pix_valid in, pix_ready out: pixel handshake
//  ready_idle out idle and initialised; frame_done out pulse at end of frame
//  tftRESET/tftRD/tftWR/tftRS/tftData out: panel bus
module tft_frame_sequencer
  import tft_frame_sequencer_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int WR_LO      = 2,
  parameter int WR_HI      = 2,
  parameter int RST_CYCLES = 280000,
  parameter int RST_WAIT   = 3360000,
  parameter int DLY_CYCLES = 3360000,
  parameter int INIT_LEN   = 32
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        start_frame,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        ready_idle,
  output logic        frame_done,
  output logic        tftRESET,
  output logic        tftRD,
  output logic        tftWR,
  output logic        tftRS,
  output logic [15:0] tftData
);
  localparam int N  = WIDTH * HEIGHT;
  localparam int PW = $clog2(N);
  localparam logic [15:0] W1 = 16'(WIDTH - 1);
  localparam logic [15:0] H1 = 16'(HEIGHT - 1);
  state_t state, nxt;
  logic busy, last, dly_pend, dly_run;
  logic [7:0] wcnt;
  logic [21:0] cnt;
  logic [5:0] idx;
  logic [PW-1:0] pixcnt;
  logic [17:0] rom_entry;
  logic [16:0] word;
  logic done, free, dly_end, init_ok, issue, rom_issue, win_issue, pix_issue;
  tft_init_rom u_rom (.addr(idx[4:0]), .entry(rom_entry));
  // engine is free on the edge that ends WR_HI, so back-to-back writes take WR_LO+WR_HI cycles
  assign done      = busy & tftWR & (wcnt == 8'(WR_HI - 1));
  assign free      = ~busy | done;
  assign dly_end   = dly_run & (cnt == 22'(DLY_CYCLES - 1));
  assign init_ok   = free & ~dly_pend & (~dly_run | dly_end);
  assign rom_issue = issue & (state == S_RST_WAIT || state == S_INIT);
  assign win_issue = issue & (state == S_WIN);
  assign pix_issue = issue & (state == S_PIX);
  always_ff @(posedge clk28) state <= rst ? S_RST_LO : nxt;
  always_comb begin
    nxt   = state;
    issue = 1'b0;
    word  = {rom_entry[ROM_RS], rom_entry[15:0]};
    case (state)
      S_RST_LO:   nxt = (cnt == 22'(RST_CYCLES - 1)) ? S_RST_WAIT : state;
      S_RST_WAIT: begin
        // first init write goes out on the same edge the wait expires
        issue = (cnt == 22'(RST_WAIT - 1));
        nxt   = issue ? S_INIT : state;
      end
      S_INIT: begin
        issue = init_ok & (idx != 6'(INIT_LEN));
        nxt   = (init_ok & (idx == 6'(INIT_LEN))) ? S_IDLE : state;
      end
      S_IDLE:     nxt = start_frame ? S_WIN : state;
      S_WIN: begin
        issue = free;
        word  = win_word(idx[3:0], W1, H1);
        nxt   = (free & (idx == 6'd9)) ? S_RAMWR : state;
      end
      S_RAMWR: begin
        issue = free;
        word  = {1'b0, TFT_CMD_RAMWR};
        nxt   = free ? S_PIX : state;
      end
      S_PIX: begin
        issue = pix_valid & pix_ready;
        word  = {1'b1, pix_data};
        nxt   = (last & done) ? S_IDLE : state;
      end
      default: nxt = S_RST_LO;
    endcase
  end
  always_comb begin
    ready_idle = (state == S_IDLE);
    pix_ready  = (state == S_PIX) & free & ~last;
    tftRESET   = (state != S_RST_LO);
    tftRD      = 1'b1;
  end
  always_ff @(posedge clk28) begin
    if (rst) begin
      busy       <= 1'b0;
      wcnt       <= '0;
      tftWR      <= 1'b1;
      tftRS      <= 1'b1;
      tftData    <= '0;
      cnt        <= '0;
      idx        <= '0;
      pixcnt     <= '0;
      last       <= 1'b0;
      dly_pend   <= 1'b0;
      dly_run    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == S_PIX) & last & done;
      if (issue) begin
        tftWR   <= 1'b0;
        busy    <= 1'b1;
        wcnt    <= '0;
        tftRS   <= word[16];
        tftData <= word[15:0];
      end else if (busy) begin
        if (~tftWR & (wcnt == 8'(WR_LO - 1))) begin
          tftWR <= 1'b1;
          wcnt  <= '0;
        end else if (done) busy <= 1'b0;
        else wcnt <= wcnt + 8'd1;
      end
      // one counter serves reset hold, post-reset wait and init delays
      cnt      <= (nxt != state || (done & dly_pend)) ? '0 : cnt + 22'd1;
      dly_pend <= (rom_issue & rom_entry[ROM_DLY]) | (dly_pend & ~done);
      dly_run  <= (done & dly_pend) | (dly_run & ~dly_end);
      idx      <= (state == S_IDLE) ? '0 : idx + 6'(rom_issue | win_issue);
      pixcnt   <= (state == S_RAMWR) ? '0 : pixcnt + PW'(pix_issue);
      last     <= (state == S_RAMWR) ? 1'b0 : last | (pix_issue & (pixcnt == PW'(N - 1)));
    end
  end
endmodule

// File: tb/tb_tft_frame_sequencer.sv
// tb_tft_frame_sequencer: scoreboard bench for reset, init, frame, underflow, ignored start, mid-frame reset
module tb_tft_frame_sequencer;
  logic clk28 = 1'b0, rst = 1'b1, start_frame = 1'b0, pix_valid = 1'b0;
  logic [15:0] pix_data = '0;
  logic pix_ready, ready_idle, frame_done, tftRESET, tftRD, tftWR, tftRS;
  logic [15:0] tftData;
  int vectors = 0, miscompares = 0, cyc = 0, fd_count = 0;
  logic [16:0] exp_q[$];
  int fall_cyc[$];
  logic wr_d = 1'b1;
  tft_frame_sequencer #(
    .WIDTH(4), .HEIGHT(2), .WR_LO(2), .WR_HI(2), .RST_CYCLES(10),
    .RST_WAIT(20), .DLY_CYCLES(5), .INIT_LEN(4)
  ) dut (
    .clk28(clk28), .rst(rst), .start_frame(start_frame), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .ready_idle(ready_idle),
    .frame_done(frame_done), .tftRESET(tftRESET), .tftRD(tftRD), .tftWR(tftWR),
    .tftRS(tftRS), .tftData(tftData)
  );
  always #5 clk28 = ~clk28;
  always @(posedge clk28) cyc <= cyc + 1;
  always @(negedge clk28) begin
    logic [16:0] e;
    if (wr_d && tftWR === 1'b0) begin
      fall_cyc.push_back(cyc);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL write_unexpected got rs=%0b data=%h want no write", tftRS, tftData);
      end else begin
        e = exp_q.pop_front();
        if ({tftRS, tftData} !== e) begin
          miscompares++;
          $display("FAIL write got rs=%0b data=%h want rs=%0b data=%h", tftRS, tftData, e[16], e[15:0]);
        end
      end
    end
    wr_d = tftWR;
    if (frame_done === 1'b1) fd_count++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic push_pixel(input logic [15:0] d);
    int t;
    t = 0;
    pix_data = d;
    pix_valid = 1'b1;
    while (pix_ready !== 1'b1 && t < 200) begin
      @(negedge clk28);
      t++;
    end
    vectors++;
    if (t >= 200) begin
      miscompares++;
      $display("FAIL pix_ready_timeout got 0 want 1 for data %h", d);
    end else exp_q.push_back({1'b1, d});
    @(negedge clk28);
    pix_valid = 1'b0;
  endtask
  task automatic test_reset();
    int lo, t, rise;
    rst = 1'b1;
    pix_valid = 1'b0;
    start_frame = 1'b0;
    repeat (3) @(negedge clk28);
    vectors++;
    if ({tftRESET, tftRD, tftWR, tftRS, tftData, pix_ready, ready_idle, frame_done} !== {4'b0111, 16'h0000, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_values got rst=%b rd=%b wr=%b rs=%b d=%h rdy=%b idle=%b fd=%b", tftRESET, tftRD, tftWR, tftRS, tftData, pix_ready, ready_idle, frame_done);
    end
    fall_cyc.delete();
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b0, 16'h0011});
    exp_q.push_back({1'b1, 16'h0055});
    exp_q.push_back({1'b0, 16'h0029});
    rst = 1'b0;
    lo = 0;
    t = 0;
    while (tftRESET === 1'b0 && t < 1000) begin
      lo++;
      t++;
      @(negedge clk28);
    end
    vectors++;
    if (lo != 10) begin
      miscompares++;
      $display("FAIL tftRESET_low got %0d cycles want 10", lo);
    end
    rise = cyc;
    t = 0;
    while (fall_cyc.size() == 0 && t < 1000) begin
      @(negedge clk28);
      t++;
    end
    vectors++;
    if (fall_cyc.size() == 0) begin
      miscompares++;
      $display("FAIL first_write got none want one");
    end else if (fall_cyc[0] - rise != 20) begin
      miscompares++;
      $display("FAIL first_write_delay got %0d want 20", fall_cyc[0] - rise);
    end
  endtask
  task automatic test_init();
    int t, ri;
    t = 0;
    while (ready_idle !== 1'b1 && t < 1000) begin
      @(negedge clk28);
      t++;
    end
    ri = cyc;
    vectors++;
    if (ready_idle !== 1'b1 || fall_cyc.size() != 4) begin
      miscompares++;
      $display("FAIL init_done got idle=%b writes=%0d want idle=1 writes=4", ready_idle, fall_cyc.size());
    end else begin
      vectors++;
      if (fall_cyc[1] - fall_cyc[0] != 9 || fall_cyc[2] - fall_cyc[1] != 4 || fall_cyc[3] - fall_cyc[2] != 4) begin
        miscompares++;
        $display("FAIL init_spacing got %0d,%0d,%0d want 9,4,4", fall_cyc[1] - fall_cyc[0], fall_cyc[2] - fall_cyc[1], fall_cyc[3] - fall_cyc[2]);
      end
      vectors++;
      if (ri - fall_cyc[3] != 4) begin
        miscompares++;
        $display("FAIL idle_timing got %0d want 4", ri - fall_cyc[3]);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL init_pending got %0d want 0", exp_q.size());
    end
  endtask
  task automatic queue_window();
    logic [16:0] w[11];
    w = '{17'h0002A, 17'h10000, 17'h10000, 17'h10000, 17'h10003,
          17'h0002B, 17'h10000, 17'h10000, 17'h10000, 17'h10001, 17'h0002C};
    for (int i = 0; i < 11; i++) exp_q.push_back(w[i]);
  endtask
  task automatic do_frame(input int gap_at, input int start_at);
    int t, base, nf, d;
    fall_cyc.delete();
    queue_window();
    base = fd_count;
    start_frame = 1'b1;
    @(negedge clk28);
    start_frame = 1'b0;
    vectors++;
    if (ready_idle !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_start got %b want 0", ready_idle);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) begin
        @(negedge clk28);
        nf = fall_cyc.size();
        repeat (7) @(negedge clk28);
        vectors++;
        if (fall_cyc.size() != nf || tftWR !== 1'b1) begin
          miscompares++;
          $display("FAIL underflow got writes=%0d wr=%b want writes=%0d wr=1", fall_cyc.size(), tftWR, nf);
        end
      end
      if (k == start_at) begin
        start_frame = 1'b1;
        @(negedge clk28);
        start_frame = 1'b0;
      end
      push_pixel(16'hF800 + 16'(k));
    end
    t = 0;
    while (frame_done !== 1'b1 && t < 200) begin
      @(negedge clk28);
      t++;
    end
    vectors++;
    if (frame_done !== 1'b1 || fall_cyc.size() != 19) begin
      miscompares++;
      $display("FAIL frame_end got fd=%b writes=%0d want fd=1 writes=19", frame_done, fall_cyc.size());
    end else begin
      vectors++;
      if (cyc - fall_cyc[18] != 4) begin
        miscompares++;
        $display("FAIL frame_done_timing got %0d want 4", cyc - fall_cyc[18]);
      end
      for (int i = 1; i < 19; i++) begin
        d = fall_cyc[i] - fall_cyc[i-1];
        if (i != 11 + gap_at) begin
          vectors++;
          if (d != 4) begin
            miscompares++;
            $display("FAIL write_spacing at %0d got %0d want 4", i, d);
          end
        end
      end
    end
    @(negedge clk28);
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_done_width got %b want 0", frame_done);
    end
    repeat (40) @(negedge clk28);
    vectors++;
    if (fd_count != base + 1 || ready_idle !== 1'b1 || exp_q.size() != 0 || fall_cyc.size() != 19) begin
      miscompares++;
      $display("FAIL frame_close got fd=%0d idle=%b pend=%0d writes=%0d want fd=%0d idle=1 pend=0 writes=19", fd_count - base, ready_idle, exp_q.size(), fall_cyc.size(), 1);
    end
  endtask
  task automatic test_frame();
    do_frame(-1, -1);
  endtask
  task automatic test_underflow();
    do_frame(4, -1);
  endtask
  task automatic test_start_ignored();
    do_frame(-1, 2);
  endtask
  task automatic test_reset_mid();
    int base;
    base = fd_count;
    fall_cyc.delete();
    queue_window();
    start_frame = 1'b1;
    @(negedge clk28);
    start_frame = 1'b0;
    for (int k = 0; k < 3; k++) push_pixel(16'hF800 + 16'(k));
    rst = 1'b1;
    @(negedge clk28);
    vectors++;
    if ({tftRESET, tftWR, pix_ready, frame_done} !== 4'b0100) begin
      miscompares++;
      $display("FAIL mid_reset got rst=%b wr=%b rdy=%b fd=%b want 0 1 0 0", tftRESET, tftWR, pix_ready, frame_done);
    end
    vectors++;
    if (exp_q.size() != 0 || fall_cyc.size() != 14) begin
      miscompares++;
      $display("FAIL mid_reset_writes got pend=%0d writes=%0d want 0 14", exp_q.size(), fall_cyc.size());
    end
    test_reset();
    test_init();
    vectors++;
    if (fd_count != base) begin
      miscompares++;
      $display("FAIL aborted_frame_done got %0d want 0", fd_count - base);
    end
  endtask
  initial begin
    test_reset();
    test_init();
    test_frame();
    test_underflow();
    test_start_ignored();
    test_reset_mid();
    test_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
